// File: rtl/branch_predictor_unit.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Zero-latency lookup; one update per cycle with no bypass; saturating update and mispredict statistics.
module branch_predictor_unit #(
    parameter int PC_WIDTH   = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [PC_WIDTH-1:0]   pred_target,
    input  logic                  upd_valid,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic                  upd_is_jump,
    input  logic                  upd_taken,
    input  logic [PC_WIDTH-1:0]   upd_target,
    input  logic                  upd_mispredict,
    input  logic                  flush,
    output logic [STAT_WIDTH-1:0] stat_updates,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(1 << (CTR_WIDTH - 1));
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   jmp_q;
    logic [TAG_W-1:0]     tag_q [ENTRIES];
    logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];
    logic [PC_WIDTH-1:0]  tgt_q [ENTRIES];

    logic [STAT_WIDTH-1:0] stat_upd_q, stat_upd_d;
    logic [STAT_WIDTH-1:0] stat_mis_q, stat_mis_d;

    logic [IDX-1:0]       lk_idx, up_idx;
    logic [TAG_W-1:0]     lk_tag, up_tag;
    logic                 up_hit, wr_en;
    logic [CTR_WIDTH-1:0] ctr_d;
    logic [PC_WIDTH-1:0]  tgt_d;

    // Byte offset within the instruction word never participates in index or tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX+1:2];
    assign lk_tag = lookup_pc[PC_WIDTH-1:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[PC_WIDTH-1:IDX+2];

    always_comb begin
        pred_hit    = !areset && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && (jmp_q[lk_idx] || ctr_q[lk_idx][CTR_WIDTH-1]);
        pred_target = pred_hit ? tgt_q[lk_idx] : '0;
    end

    always_comb begin
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        wr_en  = 1'b0;
        ctr_d  = ctr_q[up_idx];
        tgt_d  = tgt_q[up_idx];
        if (upd_valid && !flush) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    ctr_d = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : ctr_q[up_idx] + CTR_WIDTH'(1);
                    tgt_d = upd_target;
                end else begin
                    ctr_d = (ctr_q[up_idx] == '0) ? '0 : ctr_q[up_idx] - CTR_WIDTH'(1);
                end
            end else if (upd_taken || upd_is_jump) begin
                wr_en = 1'b1;
                ctr_d = CTR_WT;
                tgt_d = upd_target;
            end
        end
    end

    // Statistics count every accepted update, including ones a flush discards.
    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (upd_valid && (stat_upd_q != '1)) begin
            stat_upd_d = stat_upd_q + STAT_WIDTH'(1);
        end
        if (upd_valid && upd_mispredict && (stat_mis_q != '1)) begin
            stat_mis_d = stat_mis_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            valid_q    <= '0;
            jmp_q      <= '0;
            stat_upd_q <= '0;
            stat_mis_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
                tgt_q[i] <= '0;
            end
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
            if (flush) begin
                valid_q <= '0;
            end else if (wr_en) begin
                valid_q[up_idx] <= 1'b1;
                jmp_q[up_idx]   <= upd_is_jump;
                tag_q[up_idx]   <= up_tag;
                ctr_q[up_idx]   <= ctr_d;
                tgt_q[up_idx]   <= tgt_d;
            end
        end
    end

    assign stat_updates     = stat_upd_q;
    assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench for branch_predictor_unit (narrow statistics to exercise saturation).
module tb_branch_predictor_unit;
    localparam int PW = 32;
    localparam int SW = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic [PW-1:0] lookup_pc;
    logic          pred_hit, pred_taken;
    logic [PW-1:0] pred_target;
    logic          upd_valid, upd_is_jump, upd_taken, upd_mispredict, flush;
    logic [PW-1:0] upd_pc, upd_target;
    logic [SW-1:0] stat_updates, stat_mispredicts;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic          hit;
        logic          taken;
        logic [PW-1:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 aclk = ~aclk;

    branch_predictor_unit #(
        .PC_WIDTH(PW), .ENTRIES(16), .CTR_WIDTH(2), .STAT_WIDTH(SW)
    ) dut (
        .aclk(aclk), .areset(areset), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush(flush), .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
    );

    // Stimulus only: presents one update/flush for exactly one rising edge.
    task automatic upd(input logic vld, input logic [PW-1:0] pc, input logic jmp, input logic tk,
                       input logic [PW-1:0] tgt, input logic misp, input logic fl);
        @(negedge aclk);
        upd_valid = vld; upd_pc = pc; upd_is_jump = jmp; upd_taken = tk;
        upd_target = tgt; upd_mispredict = misp; flush = fl;
        @(posedge aclk);
        #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0; flush = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        areset = 1'b1; lookup_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 32'h40; upd_mispredict = 1'b1; flush = 1'b0;
        #2;
        n_vec++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_pred: got hit=%b taken=%b target=%h, want 0 0 0", pred_hit, pred_taken, pred_target);
        end
        @(posedge aclk); #1;
        n_vec++;
        if ({pred_hit, stat_updates, stat_mispredicts} !== {1'b0, 4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_hold: got hit=%b upd=%0d mis=%0d, want 0 0 0", pred_hit, stat_updates, stat_mispredicts);
        end
        @(negedge aclk);
        areset = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        sb.push_back({32'h100, 1'b0, 1'b0, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge aclk); lookup_pc = e.pc; #2;
            n_vec++;
            if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
                n_err++;
                $display("FAIL reset_lookup pc=%h: got %b %b %h, want %b %b %h", e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
            end
        end
        n_vec++;
        if ({stat_updates, stat_mispredicts} !== {4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_stats: got upd=%0d mis=%0d, want 0 0", stat_updates, stat_mispredicts);
        end
    endtask

    task automatic test_alloc();
        exp_t e;
        upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        sb.push_back({32'h100, 1'b1, 1'b1, 32'h40});
        sb.push_back({32'h140, 1'b0, 1'b0, 32'h0});
        sb.push_back({32'h103, 1'b1, 1'b1, 32'h40});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge aclk); lookup_pc = e.pc; #2;
            n_vec++;
            if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
                n_err++;
                $display("FAIL alloc pc=%h: got %b %b %h, want %b %b %h", e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
            end
        end
        n_vec++;
        if ({stat_updates, stat_mispredicts} !== {4'd1, 4'd0}) begin
            n_err++;
            $display("FAIL alloc_stats: got upd=%0d mis=%0d, want 1 0", stat_updates, stat_mispredicts);
        end
    endtask

    task automatic test_counter();
        exp_t e;
        int ctr = 2;
        logic [PW-1:0] tgt = 32'h40;
        for (int i = 0; i < 5; i++) begin
            logic tk = (i >= 3);
            logic [PW-1:0] nt = 32'h44 + 32'(4 * (i - 3));
            upd(1'b1, 32'h100, 1'b0, tk, tk ? nt : 32'hdead0, 1'b0, 1'b0);
            if (tk) begin ctr = (ctr == 3) ? 3 : ctr + 1; tgt = nt; end
            else    ctr = (ctr == 0) ? 0 : ctr - 1;
            sb.push_back({32'h100, 1'b1, ctr >= 2, tgt});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                @(negedge aclk); lookup_pc = e.pc; #2;
                n_vec++;
                if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
                    n_err++;
                    $display("FAIL counter step%0d: got %b %b %h, want %b %b %h", i, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
                end
            end
        end
    endtask

    task automatic test_jump();
        exp_t e;
        upd(1'b1, 32'h200, 1'b1, 1'b1, 32'h800, 1'b0, 1'b0);
        upd(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        upd(1'b1, 32'h204, 1'b1, 1'b0, 32'h900, 1'b0, 1'b0);
        upd(1'b1, 32'h208, 1'b0, 1'b0, 32'ha00, 1'b0, 1'b0);
        sb.push_back({32'h200, 1'b1, 1'b1, 32'h800});
        sb.push_back({32'h100, 1'b0, 1'b0, 32'h0});
        sb.push_back({32'h204, 1'b1, 1'b1, 32'h900});
        sb.push_back({32'h208, 1'b0, 1'b0, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge aclk); lookup_pc = e.pc; #2;
            n_vec++;
            if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
                n_err++;
                $display("FAIL jump pc=%h: got %b %b %h, want %b %b %h", e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
            end
        end
        n_vec++;
        if ({stat_updates, stat_mispredicts} !== {4'd10, 4'd0}) begin
            n_err++;
            $display("FAIL jump_stats: got upd=%0d mis=%0d, want 10 0", stat_updates, stat_mispredicts);
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        @(negedge aclk);
        upd_valid = 1'b1; upd_pc = 32'h180; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 32'h98; upd_mispredict = 1'b0; flush = 1'b0;
        lookup_pc = 32'h180; #1;
        n_vec++;
        if (pred_hit !== 1'b0) begin
            n_err++;
            $display("FAIL same_cycle_new: got hit=%b, want 0", pred_hit);
        end
        lookup_pc = 32'h200; #1;
        n_vec++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h800}) begin
            n_err++;
            $display("FAIL same_cycle_old: got hit=%b target=%h, want 1 00000800", pred_hit, pred_target);
        end
        @(posedge aclk); #1;
        upd_valid = 1'b0;
        sb.push_back({32'h180, 1'b1, 1'b1, 32'h98});
        sb.push_back({32'h200, 1'b0, 1'b0, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge aclk); lookup_pc = e.pc; #2;
            n_vec++;
            if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
                n_err++;
                $display("FAIL back_to_back pc=%h: got %b %b %h, want %b %b %h", e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
            end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        pulse_reset();
        upd(1'b0, 32'h100, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
        n_vec++;
        if ({stat_updates, stat_mispredicts} !== {4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL misp_no_valid: got upd=%0d mis=%0d, want 0 0", stat_updates, stat_mispredicts);
        end
        upd(1'b1, 32'h300, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1);
        n_vec++;
        if ({stat_updates, stat_mispredicts} !== {4'd1, 4'd1}) begin
            n_err++;
            $display("FAIL flush_stats: got upd=%0d mis=%0d, want 1 1", stat_updates, stat_mispredicts);
        end
        upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        upd(1'b1, 32'h104, 1'b1, 1'b1, 32'h50, 1'b0, 1'b0);
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        sb.push_back({32'h300, 1'b0, 1'b0, 32'h0});
        sb.push_back({32'h100, 1'b0, 1'b0, 32'h0});
        sb.push_back({32'h104, 1'b0, 1'b0, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge aclk); lookup_pc = e.pc; #2;
            n_vec++;
            if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
                n_err++;
                $display("FAIL flush pc=%h: got %b %b %h, want %b %b %h", e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
            end
        end
    endtask

    task automatic test_stat_saturation();
        exp_t e;
        pulse_reset();
        for (int i = 0; i < 20; i++) upd(1'b1, 32'h500, 1'b0, 1'b1, 32'h60, 1'b1, 1'b0);
        n_vec++;
        if ({stat_updates, stat_mispredicts} !== {4'd15, 4'd15}) begin
            n_err++;
            $display("FAIL stat_saturate: got upd=%0d mis=%0d, want 15 15", stat_updates, stat_mispredicts);
        end
        @(negedge aclk);
        upd_valid = 1'b1; upd_pc = 32'h540; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 32'h70; upd_mispredict = 1'b1; lookup_pc = 32'h500;
        #2 areset = 1'b1;
        #1;
        n_vec++;
        if ({pred_hit, pred_taken, pred_target, stat_updates, stat_mispredicts} !== {1'b0, 1'b0, 32'h0, 4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL mid_reset: got %b %b %h upd=%0d mis=%0d, want 0 0 0 0 0", pred_hit, pred_taken, pred_target, stat_updates, stat_mispredicts);
        end
        @(negedge aclk);
        areset = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        upd(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        upd(1'b1, 32'h5c4, 1'b0, 1'b1, 32'h74, 1'b0, 1'b0);
        sb.push_back({32'h540, 1'b0, 1'b0, 32'h0});
        sb.push_back({32'h500, 1'b0, 1'b0, 32'h0});
        sb.push_back({32'h5c4, 1'b1, 1'b1, 32'h74});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge aclk); lookup_pc = e.pc; #2;
            n_vec++;
            if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
                n_err++;
                $display("FAIL post_reset pc=%h: got %b %b %h, want %b %b %h", e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
            end
        end
        n_vec++;
        if ({stat_updates, stat_mispredicts} !== {4'd2, 4'd0}) begin
            n_err++;
            $display("FAIL post_reset_stats: got upd=%0d mis=%0d, want 2 0", stat_updates, stat_mispredicts);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_jump();
        test_same_cycle();
        test_flush();
        test_stat_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor_unit.md
BRANCH_PREDICTOR_UNIT -- requirements
Module: branch_predictor_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, program-counter width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth; power of two, 2..256.
REQ-003 SHALL have parameter CTR_WIDTH, default 2, saturating-counter width, 1..4.
REQ-004 SHALL have parameter STAT_WIDTH, default 32, performance-counter width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 aclk  input  1  clock, all state updates on rising edge.
REQ-007 areset  input  1  asynchronous active-high reset.
REQ-008 lookup_pc  input  PC_WIDTH  fetch-stage PC to predict.
REQ-009 pred_hit  output  1  valid entry with matching tag at lookup index.
REQ-010 pred_taken  output  1  predict redirect for lookup_pc.
REQ-011 pred_target  output  PC_WIDTH  predicted target; zero when pred_hit=0.
REQ-012 upd_valid  input  1  resolved control-flow instruction this cycle.
REQ-013 upd_pc  input  PC_WIDTH  PC of resolved instruction.
REQ-014 upd_is_jump  input  1  1 = unconditional jump, 0 = conditional branch.
REQ-015 upd_taken  input  1  resolved direction.
REQ-016 upd_target  input  PC_WIDTH  resolved target address.
REQ-017 upd_mispredict  input  1  resolving stage detected a wrong prediction; qualified by upd_valid.
REQ-018 flush  input  1  invalidate all entries.
REQ-019 stat_updates  output  STAT_WIDTH  count of accepted updates.
REQ-020 stat_mispredicts  output  STAT_WIDTH  count of accepted mispredicts.

Function
REQ-021 Index = pc[IDX+1:2], IDX = log2(ENTRIES); tag = pc[PC_WIDTH-1:IDX+2]; pc[1:0] ignored.
REQ-022 Entry = valid, tag, is_jump, counter (CTR_WIDTH), target (PC_WIDTH).
REQ-023 Lookup combinational, zero latency: pred_hit = valid && tag match at index.
REQ-024 pred_taken = pred_hit && (is_jump || counter MSB = 1).
REQ-025 Update on rising edge when upd_valid=1; result visible to lookup next cycle.
REQ-026 Update hit (valid, tag match): taken -> counter +1 saturating at 2^CTR_WIDTH-1, target <= upd_target; not taken -> counter -1 saturating at 0, target kept; is_jump <= upd_is_jump.
REQ-027 Update miss and (upd_taken || upd_is_jump): allocate/overwrite entry: valid=1, tag, is_jump, target, counter = 2^(CTR_WIDTH-1) (weakly taken).
REQ-028 Update miss and not taken and not jump: no table change.
REQ-029 Same-cycle lookup and update on same index: lookup returns pre-update contents (no bypass).
REQ-030 flush=1: all valid bits cleared on that edge; counters/targets keep value; a concurrent update is discarded, and stat counters still count it.
REQ-031 stat_updates +1 per edge with upd_valid=1; stat_mispredicts +1 per edge with upd_valid && upd_mispredict; both saturate at all-ones, never wrap.
REQ-032 upd_mispredict without upd_valid SHALL be ignored.

Reset
REQ-033 areset=1 asynchronously clears all valid bits, sets every counter to 2^(CTR_WIDTH-1)-1 (weakly not-taken), targets and is_jump to 0, stat counters to 0.
REQ-034 During reset pred_hit=0, pred_taken=0, pred_target=0; updates ignored.
REQ-035 Reset asserted mid-update: update lost; first post-release edge behaves as from empty table.

Verification
REQ-036 Reset, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0, stats 0.
REQ-037 Update pc=0x100 branch taken target=0x040; next cycle lookup 0x100 -> hit=1, taken=1, target=0x040; lookup 0x140 (same index, different tag) -> hit=0.
REQ-038 Defaults, entry 0x100 at counter 2: three not-taken updates -> counter 1 then 0 then 0, pred_taken=0, hit=1; two taken -> counter 1 then 2, pred_taken=1.
REQ-039 Jump pc=0x200 target=0x800 allocated, then not-taken update -> pred_taken stays 1 (is_jump).
REQ-040 Same edge: upd_valid=1 pc=0x300 taken, flush=1, upd_mispredict=1 -> lookup 0x300 hit=0; stat_updates=1, stat_mispredicts=1.
REQ-041 STAT_WIDTH=4: 20 mispredicting updates -> stat_mispredicts=15, stat_updates=15; areset pulse mid-sequence -> both 0 and table empty.
